ghost_sweep_scheduler: RTL and testbench
========================================

# ghost_sweep_scheduler

Sequences the four ghost movement controllers and owns the ghost mode. A free-running game-tick divider starts one sweep per tick. Each sweep steps the ghosts one at a time and checks each ghost against Pac-Man's tile position. The block also runs the scatter/chase/frightened mode timers and reports collisions to the game FSM. It sits between the top-level game FSM and the ghost controllers' step enables.

## Interface
- `TICK_DIV`, 2500000: clock cycles per game tick; must be ≥ 13.
- `SCATTER_TICKS`, 7: ticks spent in scatter before switching to chase.
- `CHASE_TICKS`, 20: ticks spent in chase before switching to scatter.
- `FRIGHT_TICKS`, 8: ticks spent in frightened per power pellet; must be ≥ 4.
- XW = $clog2(`WIDTH); YW = $clog2(`HEIGHT) (from define.v, not parameters).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pause` in 1: freezes the tick divider and the mode timers.
- `power_pellet` in 1: one-cycle pulse when Pac-Man eats a pellet.
- `pacman_x` in XW, `pacman_y` in YW: Pac-Man position.
- `ghost_x` in 4*XW, `ghost_y` in 4*YW: ghost positions. Ghost i occupies slice [i*XW +: XW] and [i*YW +: YW].
- `step_en` out 4: one-hot, one-cycle step strobe to ghost i.
- `mode` out 2: 0 = scatter, 1 = chase, 2 = frightened; 3 is never driven.
- `fright_warn` out 1: high while frightened and fright_cnt ≤ FRIGHT_TICKS/4.
- `pacman_hit` out 1: one-cycle pulse when a non-frightened ghost collides with Pac-Man.
- `ghost_eaten` out 4: one-cycle pulse on bit i when ghost i is caught while frightened.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.
- `overrun` out 1: sticky; set when a tick arrives during a busy sweep.

## Operation
Tick divider:
- tick_cnt counts 0..TICK_DIV-1 and wraps.
- tick is a one-cycle pulse when tick_cnt == TICK_DIV-1 and pause == 0.
- While paused, tick_cnt holds.

Sweep FSM, with idx[1:0]:
- IDLE: on tick, set idx=0 and go to ISSUE.
- ISSUE: step_en[idx]=1 for exactly one cycle; go to WAIT.
- WAIT: one cycle for the ghost controller to register its new position; go to CHECK.
- CHECK: compare ghost_x/ghost_y slice idx with pacman_x/pacman_y. On equality:
  - mode == 2 → ghost_eaten[idx] pulse.
  - otherwise → pacman_hit pulse.
- CHECK exit: if idx == 3, pulse sweep_done and go to IDLE; else increment idx and go to ISSUE.
- A tick while not IDLE is dropped and sets overrun. overrun clears only on reset.
- pause never aborts a sweep in progress.

Mode timers (decrement only on tick):
- Reset state: mode=0, phase_cnt=SCATTER_TICKS.
- Scatter/chase: each tick decrements phase_cnt. A tick with phase_cnt == 1 toggles scatter↔chase and loads SCATTER_TICKS or CHASE_TICKS accordingly.
- power_pellet in any mode:
  - The next cycle, mode=2 and fright_cnt=FRIGHT_TICKS.
  - If not already frightened, the current mode goes into saved_mode and phase_cnt freezes.
  - A pellet while already frightened only reloads fright_cnt.
- Frightened: each tick decrements fright_cnt. A tick with fright_cnt == 1 restores mode=saved_mode and resumes phase_cnt at its frozen value.
- Simultaneous power_pellet and tick: the pellet wins. fright_cnt loads FRIGHT_TICKS, and phase_cnt does not decrement that tick.
- Simultaneous power_pellet and CHECK: the collision uses the registered mode value from before the update.

## Timing
- Reset values:
  - step_en=0, mode=0, fright_warn=0, pacman_hit=0, ghost_eaten=0, sweep_done=0, overrun=0.
  - FSM=IDLE, tick_cnt=0, phase_cnt=SCATTER_TICKS, fright_cnt=0, saved_mode=0.
- All outputs are registered.
- Sweep timeline, with tick at cycle T:
  - step_en[0] high at T+1, step_en[1] at T+4, step_en[2] at T+7, step_en[3] at T+10.
  - CHECK for ghost i at T+3+3i; its collision pulse is visible at T+4+3i.
  - sweep_done is visible at T+13. The sweep occupies 12 cycles, so ticks never overrun when TICK_DIV ≥ 13.
- mode changes are visible the cycle after the triggering tick or pellet.
- Reset asserted mid-sweep: all state returns to reset values immediately. No partial strobes may persist after reset deasserts.

## Test plan
- Sweep order:
  - Stimulus: TICK_DIV=16, release reset, no collisions.
  - Response: step_en = 0001, 0010, 0100, 1000 at cycles 16, 19, 22, 25 after reset release; sweep_done at cycle 28; repeats every 16 cycles.
- Mode timers:
  - Stimulus: SCATTER_TICKS=2, CHASE_TICKS=3.
  - Response: mode=0 for ticks 1–2, 1 after tick 2, back to 0 after tick 5.
- Frightened:
  - Stimulus: power_pellet during chase with phase_cnt=2, FRIGHT_TICKS=4.
  - Response: mode=2 next cycle; fright_warn high after the 3rd tick; chase restored after the 4th tick; switches to scatter 2 ticks later.
- Collision:
  - Stimulus: ghost 2 at (200,60), Pac-Man at (200,60).
  - Response: one pacman_hit pulse per sweep in chase. In frightened, ghost_eaten=0100 instead and no pacman_hit.
- Pause and overrun:
  - Stimulus: pause held for 40 cycles.
  - Response: no step_en during the pause except to finish an active sweep; timers unchanged.
  - Stimulus: TICK_DIV=8 (illegal).
  - Response: overrun sets on the second tick and stays set.
- Reset mid-sweep:
  - Stimulus: reset pulsed at T+5.
  - Response: outputs 0 and mode=0 asynchronously; the first step_en comes one tick after release.

Source files
------------

// File: rtl/ghost_sweep_scheduler.sv
// ghost_sweep_scheduler
//
// Paces the four ghost controllers. A free-running divider produces one game
// tick every TICK_DIV cycles. Each tick starts a sweep that strobes each
// ghost's step enable in turn. After the ghost has had a cycle to register
// its new position, the sweep compares that position with Pac-Man's tile.
// The block also owns the scatter/chase/frightened mode timers and reports
// collisions to the game FSM.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   pause         freezes the tick divider and, with it, the mode timers
//   power_pellet  one-cycle pulse, enters (or extends) frightened mode
//   pacman_x/y    Pac-Man tile position
//   ghost_x/y     packed ghost positions, ghost i at [i*XW +: XW] / [i*YW +: YW]
//   step_en       one-hot, one-cycle step strobe per ghost
//   mode          0 scatter, 1 chase, 2 frightened
//   fright_warn   frightened and close to running out
//   pacman_hit    a non-frightened ghost landed on Pac-Man
//   ghost_eaten   ghost i was caught while frightened
//   sweep_done    last ghost of the sweep has been checked
//   overrun       sticky; a tick arrived while a sweep was still running
//
// Sweep FSM
//   state | meaning
//   IDLE  | waiting for the next game tick
//   ISSUE | step_en[idx] is being driven this cycle
//   WAIT  | ghost idx registers its new position
//   CHECK | ghost idx is compared with Pac-Man; advance idx or finish

`ifndef WIDTH
`define WIDTH 256
`endif
`ifndef HEIGHT
`define HEIGHT 128
`endif

module ghost_sweep_scheduler #(
    parameter int TICK_DIV      = 2500000,
    parameter int SCATTER_TICKS = 7,
    parameter int CHASE_TICKS   = 20,
    parameter int FRIGHT_TICKS  = 8,
    localparam int XW = $clog2(`WIDTH),
    localparam int YW = $clog2(`HEIGHT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pause,
    input  logic            power_pellet,
    input  logic [XW-1:0]   pacman_x,
    input  logic [YW-1:0]   pacman_y,
    input  logic [4*XW-1:0] ghost_x,
    input  logic [4*YW-1:0] ghost_y,
    output logic [3:0]      step_en,
    output logic [1:0]      mode,
    output logic            fright_warn,
    output logic            pacman_hit,
    output logic [3:0]      ghost_eaten,
    output logic            sweep_done,
    output logic            overrun
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMAX = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int FW   = $clog2(FRIGHT_TICKS + 1);

    localparam logic [1:0] MODE_SCATTER = 2'd0;
    localparam logic [1:0] MODE_CHASE   = 2'd1;
    localparam logic [1:0] MODE_FRIGHT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // ---------------- tick divider ----------------
    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;
    logic          tick;

    assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
    assign tick      = tick_wrap && !pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!pause) begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
        end
    end

    // ---------------- sweep FSM ----------------
    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic [3:0] step_nx;
    logic [3:0] eaten_nx;
    logic       hit_nx;
    logic       done_nx;
    logic       ghost_match;

    assign ghost_match = (ghost_x[idx*XW +: XW] == pacman_x) &&
                         (ghost_y[idx*YW +: YW] == pacman_y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            step_en     <= '0;
            pacman_hit  <= 1'b0;
            ghost_eaten <= '0;
            sweep_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            step_en     <= step_nx;
            pacman_hit  <= hit_nx;
            ghost_eaten <= eaten_nx;
            sweep_done  <= done_nx;
            overrun     <= overrun | (tick && (state != IDLE));
        end
    end

    // Strobes are computed from the next state so that they come out of a
    // register exactly in the cycle the FSM occupies ISSUE / leaves CHECK.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        step_nx  = '0;
        eaten_nx = '0;
        hit_nx   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = ISSUE;
                    idx_nx   = 2'd0;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = CHECK;
            CHECK: begin
                // mode here is the registered value, so a pellet arriving in
                // the same cycle does not change how this collision is scored.
                if (ghost_match) begin
                    if (mode == MODE_FRIGHT) begin
                        eaten_nx[idx] = 1'b1;
                    end else begin
                        hit_nx = 1'b1;
                    end
                end
                if (idx == 2'd3) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = ISSUE;
                    idx_nx   = idx + 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx == ISSUE) begin
            step_nx[idx_nx] = 1'b1;
        end
    end

    // ---------------- mode timers ----------------
    logic [PW-1:0] phase_cnt, phase_nx;
    logic [FW-1:0] fright_cnt, fright_nx;
    logic [1:0]    saved_mode, saved_nx;
    logic [1:0]    mode_nx;
    logic          warn_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode        <= MODE_SCATTER;
            phase_cnt   <= PW'(SCATTER_TICKS);
            fright_cnt  <= '0;
            saved_mode  <= MODE_SCATTER;
            fright_warn <= 1'b0;
        end else begin
            mode        <= mode_nx;
            phase_cnt   <= phase_nx;
            fright_cnt  <= fright_nx;
            saved_mode  <= saved_nx;
            fright_warn <= warn_nx;
        end
    end

    // A pellet takes priority over a coincident tick; phase_cnt is left
    // untouched for the whole frightened interval and resumes afterwards.
    always_comb begin
        mode_nx   = mode;
        phase_nx  = phase_cnt;
        fright_nx = fright_cnt;
        saved_nx  = saved_mode;
        if (power_pellet) begin
            if (mode != MODE_FRIGHT) begin
                saved_nx = mode;
            end
            mode_nx   = MODE_FRIGHT;
            fright_nx = FW'(FRIGHT_TICKS);
        end else if (tick) begin
            if (mode == MODE_FRIGHT) begin
                if (fright_cnt == FW'(1)) begin
                    mode_nx   = saved_mode;
                    fright_nx = '0;
                end else begin
                    fright_nx = fright_cnt - FW'(1);
                end
            end else if (phase_cnt == PW'(1)) begin
                if (mode == MODE_SCATTER) begin
                    mode_nx  = MODE_CHASE;
                    phase_nx = PW'(CHASE_TICKS);
                end else begin
                    mode_nx  = MODE_SCATTER;
                    phase_nx = PW'(SCATTER_TICKS);
                end
            end else begin
                phase_nx = phase_cnt - PW'(1);
            end
        end
        warn_nx = (mode_nx == MODE_FRIGHT) && (fright_nx <= FW'(FRIGHT_TICKS / 4));
    end

endmodule

// File: tb/tb_ghost_sweep_scheduler.sv
`ifndef WIDTH
`define WIDTH 256
`endif
`ifndef HEIGHT
`define HEIGHT 128
`endif

module tb_ghost_sweep_scheduler;
    localparam int XW = $clog2(`WIDTH);
    localparam int YW = $clog2(`HEIGHT);
    localparam int TD = 16;
    localparam int ST = 2;
    localparam int CT = 3;
    localparam int FT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_ov = 1'b0;
    logic pause = 1'b0;
    logic power_pellet = 1'b0;
    logic [XW-1:0]   pacman_x = '0;
    logic [YW-1:0]   pacman_y = '0;
    logic [4*XW-1:0] ghost_x = '0;
    logic [4*YW-1:0] ghost_y = '0;

    logic [3:0] step_en, ghost_eaten;
    logic [1:0] mode;
    logic       fright_warn, pacman_hit, sweep_done, overrun;

    logic [3:0] step_en_ov, ghost_eaten_ov;
    logic [1:0] mode_ov;
    logic       fright_warn_ov, pacman_hit_ov, sweep_done_ov, overrun_ov;

    ghost_sweep_scheduler #(
        .TICK_DIV(TD), .SCATTER_TICKS(ST), .CHASE_TICKS(CT), .FRIGHT_TICKS(FT)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .power_pellet(power_pellet),
        .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .step_en(step_en), .mode(mode), .fright_warn(fright_warn), .pacman_hit(pacman_hit),
        .ghost_eaten(ghost_eaten), .sweep_done(sweep_done), .overrun(overrun)
    );

    // Deliberately too-fast divider: the second tick lands inside a sweep.
    ghost_sweep_scheduler #(
        .TICK_DIV(8), .SCATTER_TICKS(ST), .CHASE_TICKS(CT), .FRIGHT_TICKS(FT)
    ) dut_ov (
        .clk(clk), .reset(reset_ov), .pause(1'b0), .power_pellet(1'b0),
        .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .step_en(step_en_ov), .mode(mode_ov), .fright_warn(fright_warn_ov),
        .pacman_hit(pacman_hit_ov), .ghost_eaten(ghost_eaten_ov),
        .sweep_done(sweep_done_ov), .overrun(overrun_ov)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: tick count, sweep start time, and mode counters.
    int  m_cnt, sw_t, m_mode, m_phase, m_fright, m_saved;
    bit  sw_valid, m_ovr;
    logic [3:0] e_step, e_eat;
    bit  e_hit, e_done, e_warn;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; sw_t = 0; sw_valid = 0; m_ovr = 0;
        m_mode = 0; m_phase = ST; m_fright = 0; m_saved = 0;
        e_step = '0; e_eat = '0; e_hit = 0; e_done = 0; e_warn = 0;
    endtask

    // Predicts the outputs visible in cycle cyc+1 from inputs during cycle cyc.
    task automatic model_eval();
        bit tick;
        int d;
        int g;
        tick = (m_cnt == TD - 1) && !pause;
        if (!pause) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
        e_step = '0; e_eat = '0; e_hit = 0; e_done = 0;
        if (sw_valid) begin
            d = cyc - sw_t;
            if (d >= 3 && d <= 12 && d % 3 == 0) begin
                g = d / 3 - 1;
                if (ghost_x[g*XW +: XW] == pacman_x && ghost_y[g*YW +: YW] == pacman_y) begin
                    if (m_mode == 2) e_eat[g] = 1'b1;
                    else e_hit = 1'b1;
                end
            end
        end
        if (tick) begin
            if (sw_valid && (cyc - sw_t) <= 12) m_ovr = 1;
            else begin
                sw_valid = 1;
                sw_t = cyc;
            end
        end
        if (sw_valid) begin
            d = cyc + 1 - sw_t;
            if (d >= 1 && d <= 10 && (d - 1) % 3 == 0) e_step[(d-1)/3] = 1'b1;
            if (d == 13) e_done = 1;
        end
        if (power_pellet) begin
            if (m_mode != 2) m_saved = m_mode;
            m_mode = 2;
            m_fright = FT;
        end else if (tick) begin
            if (m_mode == 2) begin
                m_fright--;
                if (m_fright == 0) m_mode = m_saved;
            end else begin
                m_phase--;
                if (m_phase == 0) begin
                    m_mode = 1 - m_mode;
                    m_phase = (m_mode == 1) ? CT : ST;
                end
            end
        end
        e_warn = (m_mode == 2) && (m_fright <= FT / 4);
    endtask

    task automatic check_all();
        chk("step_en", 8'(step_en), 8'(e_step));
        chk("mode", 8'(mode), 8'(m_mode));
        chk("fright_warn", 8'(fright_warn), 8'(e_warn));
        chk("pacman_hit", 8'(pacman_hit), 8'(e_hit));
        chk("ghost_eaten", 8'(ghost_eaten), 8'(e_eat));
        chk("sweep_done", 8'(sweep_done), 8'(e_done));
        chk("overrun", 8'(overrun), 8'(m_ovr));
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_step_en"}, 8'(step_en), 8'h00);
        chk({tag, "_mode"}, 8'(mode), 8'h00);
        chk({tag, "_warn"}, 8'(fright_warn), 8'h00);
        chk({tag, "_hit"}, 8'(pacman_hit), 8'h00);
        chk({tag, "_eaten"}, 8'(ghost_eaten), 8'h00);
        chk({tag, "_done"}, 8'(sweep_done), 8'h00);
        chk({tag, "_overrun"}, 8'(overrun), 8'h00);
    endtask

    task automatic place_ghosts_apart();
        for (int i = 0; i < 4; i++) begin
            ghost_x[i*XW +: XW] = XW'(10 * i + 3);
            ghost_y[i*YW +: YW] = YW'(i + 1);
        end
    endtask

    int pause_left = 0;

    task automatic randomize_inputs();
        if ($urandom_range(49) == 0) begin
            pacman_x = XW'($urandom);
            pacman_y = YW'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3) == 0) begin
                ghost_x[i*XW +: XW] = pacman_x;
                ghost_y[i*YW +: YW] = pacman_y;
            end else begin
                ghost_x[i*XW +: XW] = XW'($urandom);
                ghost_y[i*YW +: YW] = YW'($urandom);
            end
        end
        if (pause_left > 0) begin
            pause_left--;
            pause = 1'b1;
        end else begin
            pause = 1'b0;
            if ($urandom_range(99) == 0) pause_left = $urandom_range(40, 5);
        end
        power_pellet = ($urandom_range(59) == 0);
    endtask

    initial begin
        int hits;
        int eaten;
        int first_step;
        int guard;

        pacman_x = XW'(200);
        pacman_y = YW'(60);
        place_ghosts_apart();
        model_reset();
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_hold");
        reset = 1'b1;
        reset_ov = 1'b1;
        cyc = 0;

        // Sweep order and mode timeline, no collisions.
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (cyc == 16) chk("order_g0", 8'(step_en), 8'h01);
            if (cyc == 19) chk("order_g1", 8'(step_en), 8'h02);
            if (cyc == 22) chk("order_g2", 8'(step_en), 8'h04);
            if (cyc == 25) chk("order_g3", 8'(step_en), 8'h08);
            if (cyc == 28) chk("done_at_28", 8'(sweep_done), 8'h01);
            if (cyc == 32) chk("repeat_g0", 8'(step_en), 8'h01);
            if (cyc == 31) chk("mode_before_tick2", 8'(mode), 8'h00);
            if (cyc == 32) chk("mode_after_tick2", 8'(mode), 8'h01);
            if (cyc == 80) chk("mode_after_tick5", 8'(mode), 8'h00);
            if (cyc == 8)  chk("ov_first_step", 8'(step_en_ov), 8'h01);
            if (cyc == 15) chk("ov_clear_before", 8'(overrun_ov), 8'h00);
            if (cyc == 16) chk("ov_set_tick2", 8'(overrun_ov), 8'h01);
        end

        // Ghost 2 sits on Pac-Man: one hit per sweep outside frightened.
        ghost_x[2*XW +: XW] = pacman_x;
        ghost_y[2*YW +: YW] = pacman_y;
        hits = 0;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (pacman_hit) hits++;
        end
        chk("hits_per_4_sweeps", 8'(hits), 8'd4);

        power_pellet = 1'b1;
        cycle();
        power_pellet = 1'b0;
        chk("fright_entered", 8'(mode), 8'h02);
        hits = 0;
        eaten = 0;
        for (int k = 0; k < 48; k++) begin
            cycle();
            if (pacman_hit) hits++;
            if (ghost_eaten == 4'b0100) eaten++;
        end
        chk("no_hit_frightened", 8'(hits), 8'd0);
        chk("eaten_seen", 8'(eaten >= 2), 8'd1);

        // Long pause.
        pause = 1'b1;
        for (int k = 0; k < 40; k++) cycle();
        pause = 1'b0;

        for (int k = 0; k < 1500; k++) begin
            randomize_inputs();
            cycle();
        end

        // Reset five cycles into a sweep.
        pause = 1'b0;
        pause_left = 0;
        power_pellet = 1'b0;
        guard = 0;
        while (!(sw_valid && (cyc - sw_t) == 5) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("reach_mid_sweep", 8'(guard < 200), 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero_outputs("reset_held");
        reset = 1'b1;
        cyc = 0;
        first_step = -1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (first_step < 0 && step_en != 4'b0000) first_step = cyc;
        end
        chk("first_step_after_reset", 8'(first_step), 8'd16);

        for (int k = 0; k < 200; k++) begin
            randomize_inputs();
            cycle();
        end

        chk("ov_sticky", 8'(overrun_ov), 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
